// File: rtl/imem_boot_loader_pkg.sv
// Shared types and sizing constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    HDR_LO  = 3'd0,
    HDR_HI  = 3'd1,
    COLLECT = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Packs a byte stream into little-endian words; word_c already includes the byte
// being accepted so the caller can capture a full word on the fourth byte.
module byte_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              clear,
  output logic [WORD_W-1:0] word_c,
  output logic              word_complete_c
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shift_q;

  always_comb begin
    word_c = shift_q;
    if (byte_valid) word_c[{idx_q, 3'b000} +: 8] = byte_data;
    word_complete_c = byte_valid && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid) begin
      shift_q <= word_c;
      idx_q   <= word_complete_c ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory, holding the
// CPU in reset until the last word is written.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              load_ins,
  output logic [ADDR_W-1:0] load_addr,
  output logic [WORD_W-1:0] load_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = 8 * HDR_BYTES;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]  word_addr_q, word_addr_d;
  logic               xfer_c;
  logic               asm_clear_c;
  logic [WORD_W-1:0]  word_c;
  logic               word_complete_c;
  logic               load_ins_d;
  logic [ADDR_W-1:0]  load_addr_d;
  logic [WORD_W-1:0]  load_data_d;
  logic               s_ready_d, cpu_hold_d, done_d, error_d;

  assign xfer_c = s_valid && s_ready;

  byte_word_assembler u_asm (
    .clk             (clk),
    .reset           (reset),
    .byte_valid      (xfer_c && (state_q == COLLECT)),
    .byte_data       (s_data),
    .clear           (asm_clear_c),
    .word_c          (word_c),
    .word_complete_c (word_complete_c)
  );

  // Next-state, counters and registered-output inputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_cnt_d    = wr_cnt_q;
    word_addr_d = word_addr_q;
    asm_clear_c = 1'b0;
    load_ins_d  = 1'b0;
    load_addr_d = load_addr;
    load_data_d = load_data;
    unique case (state_q)
      HDR_LO: if (xfer_c) begin
        cnt_d[7:0] = s_data;
        state_d    = HDR_HI;
      end
      HDR_HI: if (xfer_c) begin
        cnt_d[CNT_W-1:8] = s_data;
        // Header is rejected when empty or larger than the memory.
        if (cnt_d == '0 || {1'b0, cnt_d} > (CNT_W + 1)'(IMEM_DEPTH)) begin
          state_d = ERR;
        end else begin
          state_d     = COLLECT;
          wr_cnt_d    = '0;
          word_addr_d = ADDR_W'(BASE_ADDR);
          asm_clear_c = 1'b1;
        end
      end
      COLLECT: if (word_complete_c) begin
        state_d     = WRITE;
        load_ins_d  = 1'b1;
        load_addr_d = word_addr_q;
        load_data_d = word_c;
      end
      WRITE: begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (wr_cnt_d == cnt_q) begin
          state_d = RUN;
        end else begin
          word_addr_d = word_addr_q + ADDR_W'(1);
          state_d     = COLLECT;
        end
      end
      RUN, ERR: if (reload) begin
        state_d = HDR_LO;
        cnt_d   = '0;
      end
      default: state_d = HDR_LO;
    endcase
    s_ready_d  = (state_d == HDR_LO) || (state_d == HDR_HI) || (state_d == COLLECT);
    done_d     = (state_q == RUN) && (state_d == RUN);
    error_d    = (state_q == ERR) && (state_d == ERR);
    cpu_hold_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HDR_LO;
      cnt_q       <= '0;
      wr_cnt_q    <= '0;
      word_addr_q <= '0;
      s_ready     <= 1'b1;
      load_ins    <= 1'b0;
      load_addr   <= '0;
      load_data   <= '0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      word_addr_q <= word_addr_d;
      s_ready     <= s_ready_d;
      load_ins    <= load_ins_d;
      load_addr   <= load_addr_d;
      load_data   <= load_data_d;
      cpu_hold    <= cpu_hold_d;
      done        <= done_d;
      error       <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as bytes are
// driven and matched against each load_ins pulse.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              reload = 1'b0;
  logic              load_ins;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              cpu_hold, done, error;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  n_writes = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  imem_boot_loader #(.ADDR_W(ADDR_W), .IMEM_DEPTH(1024), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .reload(reload), .load_ins(load_ins), .load_addr(load_addr), .load_data(load_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (load_ins === 1'b1) begin
      n_writes++;
      last_addr = load_addr;
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(load_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(load_addr), 32'(e.addr));
        check("wr_data", load_data, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    s_data  = b;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      guard++;
      if (guard > 50) begin
        check("accept_timeout", 32'(s_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a, input bit expect_wr);
    wr_t e;
    if (expect_wr) begin
      e.addr = a;
      e.data = w;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_load_ins"}, 32'(load_ins), 32'd0);
    check({tag, "_load_addr"}, 32'(load_addr), 32'd0);
    check({tag, "_load_data"}, load_data, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // After the final accepted byte: done/cpu_hold change at the second edge.
  task automatic check_run_entry(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_early"}, 32'(done), 32'd0);
    check({tag, "_hold_early"}, 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_err(input string tag, input int writes_before);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_error"}, 32'(error), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_no_write"}, 32'(n_writes), 32'(writes_before));
  endtask

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_reset_outputs("rst");

    // 1: two-word image, continuous stream
    send_hdr(16'd2);
    send_word(32'h0000_0513, 10'd0, 1'b1);
    send_word(32'h0010_0593, 10'd1, 1'b1);
    check_run_entry("t1");
    check("t1_writes", 32'(n_writes), 32'd2);

    // 2: zero-length header
    do_reset();
    w0 = n_writes;
    send_hdr(16'd0);
    check_err("t2", w0);

    // 3: oversize header rejected, full-depth header accepted
    do_reset();
    w0 = n_writes;
    send_hdr(16'd1025);
    check_err("t3_1025", w0);
    do_reset();
    send_hdr(16'd1024);
    for (int i = 0; i < 1024; i++)
      send_word(32'(i) * 32'h0001_0003 ^ 32'hA5C3_0000, ADDR_W'(i), 1'b1);
    check_run_entry("t3_1024");
    check("t3_last_addr", 32'(last_addr), 32'd1023);

    // 4: gap in s_valid between bytes 2 and 3 of word 0
    do_reset();
    w0 = n_writes;
    send_hdr(16'd2);
    begin
      wr_t e;
      e.addr = 10'd0;
      e.data = 32'h0000_0513;
      exp_q.push_back(e);
    end
    send_byte(8'h13);
    send_byte(8'h05);
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0010_0593, 10'd1, 1'b1);
    check_run_entry("t4");
    check("t4_writes", 32'(n_writes - w0), 32'd2);

    // 5: reset in the middle of word 1 discards it
    do_reset();
    send_hdr(16'd2);
    send_word(32'h1234_5678, 10'd0, 1'b1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    w0 = n_writes;
    do_reset();
    check_reset_outputs("t5_rst");
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_write", 32'(n_writes), 32'(w0));
    send_hdr(16'd1);
    send_word(32'hDEAD_BEEF, 10'd0, 1'b1);
    check_run_entry("t5");

    // 6: reload from RUN starts a fresh load
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("t6_hold", 32'(cpu_hold), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_s_ready", 32'(s_ready), 32'd1);
    w0 = n_writes;
    send_hdr(16'd1);
    send_word(32'hDEAD_BEEF, 10'd0, 1'b1);
    check_run_entry("t6");
    check("t6_writes", 32'(n_writes - w0), 32'd1);

    // reload from ERR clears error
    do_reset();
    w0 = n_writes;
    send_hdr(16'd0);
    check_err("t7", w0);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("t7_error_clr", 32'(error), 32'd0);
    check("t7_s_ready", 32'(s_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
